// File: rtl/ft245_sync_ctrl.sv
// rtl/ft245_sync_ctrl.sv - FT245 synchronous FIFO bus master; FT245_CTRL_STATS_EN adds traffic counters
module ft245_sync_ctrl #(
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 256,
  parameter int TURN_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxfn,
  input  logic              txen,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rdn,
  output logic              wrn,
  output logic              oen,
  output logic              rx_wr,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_afull,
  output logic              tx_rd,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_empty
`ifdef FT245_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_rx_words,
  output logic [31:0]       stat_tx_words,
  output logic [15:0]       stat_bursts
`endif
);

  localparam int CNT_W  = $clog2(BURST_MAX + 1);
  localparam int TURN_W = $clog2(TURN_CYC + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_OE    = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    TURN     = 3'd4
  } state_t;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_t;

  state_t             state, state_nxt;
  dir_t               last_dir, last_dir_nxt;
  logic [CNT_W-1:0]   bcnt, bcnt_nxt;
  logic [TURN_W-1:0]  tcnt, tcnt_nxt;
  logic               rdn_nxt, wrn_nxt, oen_nxt, rx_wr_nxt;
  logic               hold_v;
  logic               rd_ok, wr_ok;
  logic               accept, sent;
  logic               last_word;

  // dout doubles as the TX hold register, so hold_v says whether it carries an unsent word
  assign rd_ok     = !rxfn && !rx_afull;
  assign wr_ok     = !txen && hold_v;
  assign accept    = (state == RD_BURST) && !rdn && !rxfn;
  assign sent      = (state == WR_BURST) && !wrn && !txen;
  assign last_word = (bcnt == CNT_W'(BURST_MAX - 1));
  assign tx_rd     = !rst && !tx_empty && (!hold_v || sent);

  // State, arbitration memory and registered bus strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_dir <= DIR_WR;
      bcnt     <= '0;
      tcnt     <= '0;
      rdn      <= 1'b1;
      wrn      <= 1'b1;
      oen      <= 1'b1;
      rx_wr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_dir <= last_dir_nxt;
      bcnt     <= bcnt_nxt;
      tcnt     <= tcnt_nxt;
      rdn      <= rdn_nxt;
      wrn      <= wrn_nxt;
      oen      <= oen_nxt;
      rx_wr    <= rx_wr_nxt;
    end
  end

  // Next state plus next value of every bus strobe (strobes change only on the clock)
  always_comb begin
    state_nxt    = state;
    last_dir_nxt = last_dir;
    bcnt_nxt     = bcnt;
    tcnt_nxt     = tcnt;
    rdn_nxt      = rdn;
    wrn_nxt      = wrn;
    oen_nxt      = oen;
    rx_wr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        // Reads win unless a write is also ready and the last burst was a read
        if (rd_ok && (!wr_ok || last_dir == DIR_WR)) begin
          state_nxt    = RD_OE;
          last_dir_nxt = DIR_RD;
          oen_nxt      = 1'b0;
          bcnt_nxt     = '0;
        end else if (wr_ok) begin
          state_nxt    = WR_BURST;
          last_dir_nxt = DIR_WR;
          wrn_nxt      = 1'b0;
          bcnt_nxt     = '0;
        end
      end
      RD_OE: begin
        // Chip gets one cycle of output enable before the first read strobe
        state_nxt = RD_BURST;
        rdn_nxt   = 1'b0;
        bcnt_nxt  = '0;
      end
      RD_BURST: begin
        if (accept) begin
          rx_wr_nxt = 1'b1;
          bcnt_nxt  = bcnt + CNT_W'(1);
        end
        // A word sampled on the exit edge still lands; afull leaves two slots for it
        if (rxfn || rx_afull || (accept && last_word)) begin
          state_nxt = TURN;
          rdn_nxt   = 1'b1;
          oen_nxt   = 1'b1;
          tcnt_nxt  = '0;
        end
      end
      WR_BURST: begin
        if (sent) begin
          bcnt_nxt = bcnt + CNT_W'(1);
        end
        // txen high means the current word was not taken and stays in the hold register
        if (txen || (sent && (tx_empty || last_word))) begin
          state_nxt = TURN;
          wrn_nxt   = 1'b1;
          tcnt_nxt  = '0;
        end
      end
      TURN: begin
        if (tcnt == TURN_W'(TURN_CYC - 1)) begin
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + TURN_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // RX capture: word read from the bus is pushed one cycle after its strobe edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= '0;
    end else if (accept) begin
      rx_data <= din;
    end
  end

  // TX hold register: refilled from the FWFT head whenever it is empty or just sent
  always_ff @(posedge clk) begin
    if (rst) begin
      dout   <= '0;
      hold_v <= 1'b0;
    end else if (tx_rd) begin
      dout   <= tx_data;
      hold_v <= 1'b1;
    end else if (sent) begin
      hold_v <= 1'b0;
    end
  end

`ifdef FT245_CTRL_STATS_EN
  // Traffic counters, wrapping at full scale
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rx_words <= '0;
      stat_tx_words <= '0;
      stat_bursts   <= '0;
    end else begin
      if (accept) begin
        stat_rx_words <= stat_rx_words + 32'd1;
      end
      if (sent) begin
        stat_tx_words <= stat_tx_words + 32'd1;
      end
      if ((state == IDLE) && (state_nxt != IDLE)) begin
        stat_bursts <= stat_bursts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ft245_sync_ctrl.sv
// tb/tb_ft245_sync_ctrl.sv - self-checking bench for ft245_sync_ctrl with chip and FIFO models
module tb_ft245_sync_ctrl;

  localparam int BURST_MAX = 4;
  localparam int TURN_CYC  = 2;
  localparam int RX_CAP    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxfn, txen, rx_afull, tx_empty;
  logic [31:0] din, tx_data;
  logic [31:0] dout, rx_data;
  logic        rdn, wrn, oen, rx_wr, tx_rd;
`ifdef FT245_CTRL_STATS_EN
  logic [31:0] stat_rx_words, stat_tx_words;
  logic [15:0] stat_bursts;
`endif

  always #5 clk = ~clk;

  ft245_sync_ctrl #(.DATA_W(32), .BURST_MAX(BURST_MAX), .TURN_CYC(TURN_CYC)) dut (
    .clk(clk), .rst(rst), .rxfn(rxfn), .txen(txen), .din(din), .dout(dout),
    .rdn(rdn), .wrn(wrn), .oen(oen), .rx_wr(rx_wr), .rx_data(rx_data),
    .rx_afull(rx_afull), .tx_rd(tx_rd), .tx_data(tx_data), .tx_empty(tx_empty)
`ifdef FT245_CTRL_STATS_EN
    , .stat_rx_words(stat_rx_words), .stat_tx_words(stat_tx_words), .stat_bursts(stat_bursts)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] chip_rx_q[$];
  logic [31:0] tx_fifo_q[$];
  logic [31:0] exp_tx_q[$];
  logic        dir_log[$];
  int          len_log[$];
  int          rx_fill, rx_cnt, tx_sent, cur_words, oen_run, idle_run, drain_mode;
  logic        rx_block, txen_block;

  typedef struct {
    int          n_rx;
    int          n_tx;
    int          drain;
    int          exp_rx;
    int          exp_tx;
    int          nb;
    logic [7:0]  dirs;
    logic [31:0] lens;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    rxfn = rx_block || (chip_rx_q.size() == 0);
    din  = 32'hdead_beef;
    if (chip_rx_q.size() != 0) din = chip_rx_q[0];
    txen     = txen_block;
    tx_empty = (tx_fifo_q.size() == 0);
    tx_data  = 32'h0;
    if (!tx_empty) tx_data = tx_fifo_q[0];
    rx_afull = (RX_CAP - rx_fill) <= 2;
  endtask

  task automatic push_tx(input logic [31:0] w);
    tx_fifo_q.push_back(w);
    exp_tx_q.push_back(w);
  endtask

  // One clock: snapshot what the edge sees, then score the chip, FIFOs and bus rules
  task automatic tick();
    logic        p_rdn, p_wrn, p_oen, p_rxfn, p_txen, p_txrd, p_empty, p_rst, xrx, xtx;
    logic [31:0] p_dout, w, w2;
    drive();
    @(negedge clk);
    p_rdn = rdn; p_wrn = wrn; p_oen = oen; p_rxfn = rxfn; p_txen = txen;
    p_txrd = tx_rd; p_empty = tx_empty; p_rst = rst; p_dout = dout;
    @(posedge clk);
    #1;
    xrx = !p_rdn && !p_rxfn;
    xtx = !p_wrn && !p_txen;
    w = 32'h0;
    if (xrx) w = chip_rx_q.pop_front();
    chk("rx_wr_latency", rx_wr, xrx && !p_rst);
    if (rx_wr) begin
      rx_cnt++;
      rx_fill++;
      if (xrx && !p_rst) chk("rx_data", rx_data, w);
    end
    chk("rx_overflow", rx_fill > RX_CAP, 0);
    if (xtx) begin
      tx_sent++;
      chk("tx_extra_word", exp_tx_q.size() != 0, 1);
      if (exp_tx_q.size() != 0) chk("tx_word", p_dout, exp_tx_q.pop_front());
    end
    chk("tx_rd_when_empty", p_txrd && p_empty, 0);
    if (p_txrd && !p_empty) w2 = tx_fifo_q.pop_front();
    if (p_rst) begin
      exp_tx_q = tx_fifo_q;
      idle_run = 100;
    end
    if (xrx || xtx) cur_words++;
    chk("bus_conflict", !wrn && (!rdn || !oen), 0);
    chk("rdn_without_oen", !rdn && oen, 0);
    if ((p_oen && !oen) || (p_wrn && !wrn)) begin
      chk("turnaround", idle_run >= TURN_CYC, 1);
      dir_log.push_back(!wrn);
      cur_words = 0;
      oen_run = 0;
    end
    if (p_rdn && !rdn) chk("oen_lead", oen_run, 1);
    if (!oen && rdn) oen_run++;
    if ((!p_oen && oen) || (!p_wrn && wrn)) begin
      chk("burst_len", cur_words <= BURST_MAX, 1);
      len_log.push_back(cur_words);
    end
    idle_run = (rdn && wrn && oen) ? idle_run + 1 : 0;
    if (rx_fill > 0 && (drain_mode == 1 || (drain_mode == 2 && $urandom_range(0, 1) == 1)))
      rx_fill--;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_block = 1'b1;
    txen_block = 1'b1;
    chip_rx_q.delete();
    tx_fifo_q.delete();
    exp_tx_q.delete();
    rx_fill = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int nb0;
    logic [7:0]  dirs_l;
    logic [31:0] lens_l;
    //          n_rx n_tx drain exp_rx exp_tx nb dirs(1=WR) lens(nibble per burst)
    vt[0] = '{8,  0,  1, 8,  0,  2, 8'b000000, 32'h44};
    vt[1] = '{0,  5,  1, 0,  5,  2, 8'b000011, 32'h14};
    vt[2] = '{10, 10, 1, 10, 10, 6, 8'b101010, 32'h224444};
    vt[3] = '{10, 0,  0, 7,  0,  2, 8'b000000, 32'h34};
    vt[4] = '{3,  1,  1, 3,  1,  2, 8'b000010, 32'h13};
    vt[5] = '{1,  0,  1, 1,  0,  1, 8'b000000, 32'h1};

    rst = 1'b1; rx_block = 1'b1; txen_block = 1'b1; drain_mode = 1;
    rx_fill = 0; rx_cnt = 0; tx_sent = 0; cur_words = 0; oen_run = 0; idle_run = 100;
    drive();
    repeat (2) @(posedge clk);
    #1;

    // Reset values, with a word waiting in the TX FIFO
    push_tx(32'h5555_0000);
    tick();
    chk("rst_rdn", rdn, 1); chk("rst_wrn", wrn, 1); chk("rst_oen", oen, 1);
    chk("rst_dout", dout, 0); chk("rst_rx_wr", rx_wr, 0); chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_rd", tx_rd, 0);

    // Table of burst scenarios
    for (int v = 0; v < 6; v++) begin
      do_reset();
      drain_mode = vt[v].drain;
      for (int i = 0; i < vt[v].n_rx; i++) chip_rx_q.push_back(32'h1000_0000 + 32'(v * 256 + i));
      for (int i = 0; i < vt[v].n_tx; i++) push_tx(32'h2000_0000 + 32'(v * 256 + i));
      repeat (3) tick();
      dir_log.delete(); len_log.delete(); rx_cnt = 0; tx_sent = 0;
      rx_block = 1'b0; txen_block = 1'b0;
      repeat (100) tick();
      chk($sformatf("v%0d_rx_words", v), rx_cnt, vt[v].exp_rx);
      chk($sformatf("v%0d_tx_words", v), tx_sent, vt[v].exp_tx);
      chk($sformatf("v%0d_bursts", v), dir_log.size(), vt[v].nb);
      chk($sformatf("v%0d_burst_ends", v), len_log.size(), vt[v].nb);
      dirs_l = vt[v].dirs;
      lens_l = vt[v].lens;
      for (int i = 0; i < vt[v].nb && i < dir_log.size() && i < len_log.size(); i++) begin
        chk($sformatf("v%0d_dir%0d", v, i), dir_log[i], dirs_l[i]);
        chk($sformatf("v%0d_len%0d", v, i), len_log[i], lens_l[4*i +: 4]);
      end
    end

    // txen rises after word 3 of 6: strobe releases, word 4 waits in hold and goes later
    do_reset();
    drain_mode = 1;
    for (int i = 0; i < 6; i++) push_tx(32'ha000_0000 + 32'(i));
    repeat (3) tick();
    tx_sent = 0;
    txen_block = 1'b0;
    for (int i = 0; i < 40 && tx_sent != 3; i++) tick();
    chk("h1_reach3", tx_sent, 3);
    txen_block = 1'b1;
    tick();
    chk("h1_wrn_high", wrn, 1);
    chk("h1_not_sent", tx_sent, 3);
    chk("h1_hold_word", dout, 32'ha000_0003);
    repeat (4) tick();
    chk("h1_wrn_stays", wrn, 1);
    txen_block = 1'b0;
    repeat (40) tick();
    chk("h1_all_sent", tx_sent, 6);
    chk("h1_nothing_left", exp_tx_q.size(), 0);

    // Reset in the middle of a read burst
    do_reset();
    drain_mode = 1;
    for (int i = 0; i < 8; i++) chip_rx_q.push_back(32'hb000_0000 + 32'(i));
    repeat (2) tick();
    rx_cnt = 0;
    rx_block = 1'b0;
    for (int i = 0; i < 40 && rx_cnt < 2; i++) tick();
    chk("h3_in_burst", rx_cnt >= 2, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("h3_rdn", rdn, 1); chk("h3_oen", oen, 1); chk("h3_wrn", wrn, 1); chk("h3_rx_wr", rx_wr, 0);
    nb0 = dir_log.size();
    repeat (60) tick();
    chk("h3_resumed", dir_log.size() > nb0, 1);
    chk("h3_drained", chip_rx_q.size(), 0);

    // Random traffic against the chip/FIFO models
    do_reset();
    drain_mode = 2;
    for (int c = 0; c < 2000; c++) begin
      rx_block   = ($urandom_range(0, 7) == 0);
      txen_block = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 5) == 0) chip_rx_q.push_back($urandom);
      if ($urandom_range(0, 5) == 0) push_tx($urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; rx_block = 1'b0; txen_block = 1'b0; drain_mode = 1;
    for (int c = 0; c < 3000 && (chip_rx_q.size() != 0 || exp_tx_q.size() != 0); c++) tick();
    repeat (10) tick();
    chk("rand_rx_drained", chip_rx_q.size(), 0);
    chk("rand_tx_drained", exp_tx_q.size(), 0);
    chk("rand_fifo_empty", tx_fifo_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
